sm4_round_key_buffer: RTL
=========================

SM4_ROUND_KEY_BUFFER -- requirements
Module: sm4_round_key_buffer

Interface
REQ-001: No parameters; the buffer holds exactly 32 round keys of 32 bits each.
REQ-002: clk  input  1  single clock; all state changes on the rising edge.
REQ-003: rst  input  1  reset, synchronous, active-high.
REQ-004: key_start_in  input  1  one-cycle pulse; a new key schedule follows and the stored set is invalidated.
REQ-005: key_valid_in  input  1  round-key write strobe from the key-expansion engine.
REQ-006: key_round_in  input  5  index (0..31) of the round key on round_key_in.
REQ-007: round_key_in  input  32  round key rk[key_round_in].
REQ-008: rd_start_in  input  1  one-cycle pulse; stream all 32 keys for one block.
REQ-009: decrypt_in  input  1  sampled with an accepted rd_start_in; 0 = order rk0..rk31, 1 = order rk31..rk0.
REQ-010: key_ready_out  output  1  complete key set stored and readable.
REQ-011: rk_valid_out  output  1  rk_out is valid this cycle.
REQ-012: rk_out  output  32  streamed round key.
REQ-013: rk_round_out  output  5  datapath round number (0..31) of the current rk_out, independent of direction.
REQ-014: rd_done_out  output  1  pulse coincident with the 32nd rk_valid_out of a stream.
REQ-015: error_out  output  1  one-cycle pulse on a protocol violation.

Function
REQ-016: FSM states EMPTY, LOADING, READY and STREAMING; reset state EMPTY.
REQ-017: EMPTY or READY or STREAMING with key_start_in -> LOADING, expected write index = 0, key_ready_out = 0 from the next cycle.
REQ-018: STREAMING aborted by key_start_in -> rk_valid_out = 0 from the next cycle; rd_done_out not asserted.
REQ-019: LOADING, key_valid_in with key_round_in == expected index -> store the key and increment the expected index.
REQ-020: LOADING, key_valid_in with index mismatch -> error_out pulse next cycle; state EMPTY; key not stored.
REQ-021: Write of index 31 accepted -> READY; key_ready_out = 1 the next cycle.
REQ-022: key_valid_in outside LOADING -> ignored and error_out pulse.
REQ-023: READY with rd_start_in -> STREAMING; capture decrypt_in; first rk_valid_out the next cycle (latency 1).
REQ-024: Stream runs 32 consecutive cycles with no gaps and no backpressure; rk_round_out counts 0..31.
REQ-025: Forward stream: rk_out = rk[rk_round_out].
REQ-026: Reverse stream: rk_out = rk[31 - rk_round_out].
REQ-027: Final stream cycle: rd_done_out = 1; return to READY.
REQ-028: rd_start_in in the same cycle as rd_done_out -> accepted; next stream starts the following cycle with no idle cycle; decrypt_in re-sampled.
REQ-029: rd_start_in mid-stream (not the final cycle) -> ignored and error_out pulse.
REQ-030: rd_start_in in EMPTY or LOADING -> ignored and error_out pulse.
REQ-031: key_start_in and rd_start_in in the same cycle -> key_start_in wins; error_out pulse.
REQ-032: The stored key set is retained and reusable for any number of streams until the next key_start_in.
REQ-033: rk_out and rk_round_out = 0 whenever rk_valid_out = 0.
REQ-034: All outputs registered.

Reset
REQ-035: rst on any clock edge -> state EMPTY and write index 0.
REQ-036: While rst is asserted, all outputs are 0.
REQ-037: rst mid-stream or mid-load terminates the operation with no rd_done_out pulse.
REQ-038: Stored key contents need not be cleared on reset; they are unreadable until a new complete load.

Verification
REQ-039: Load the SM4 standard-vector schedule (key 0123456789abcdeffedcba9876543210) -> key_ready_out = 1 one cycle after rk31 is written.
REQ-040: Forward stream after that load -> cycle 1 rk_out = f12186f9 with rk_round_out = 0; cycle 32 rk_out = 9124a012 with rd_done_out = 1.
REQ-041: Reverse stream with rk[i] = 0x10000000+i -> rk_out 0x1000001F down to 0x10000000; rk_round_out 0..31.
REQ-042: Write sequence 0,1,2,4 -> error_out pulse; key_ready_out = 0; a subsequent rd_start_in -> error_out pulse and no rk_valid_out.
REQ-043: Back-to-back: rd_start_in on the rd_done_out cycle with decrypt_in flipped -> 64 contiguous valid cycles, second half reversed.
REQ-044: key_start_in at stream cycle 10 -> rk_valid_out = 0 from cycle 11, no rd_done_out; rst mid-load -> all outputs 0, state EMPTY.

Source files
------------

// File: rtl/sm4_round_key_buffer_if.sv
// Handshake bundle between the SM4 key-expansion engine, the round-key buffer
// and the round datapath that consumes the streamed keys.
interface sm4_round_key_buffer_if;
    logic        key_start_in;
    logic        key_valid_in;
    logic [4:0]  key_round_in;
    logic [31:0] round_key_in;
    logic        rd_start_in;
    logic        decrypt_in;
    logic        key_ready_out;
    logic        rk_valid_out;
    logic [31:0] rk_out;
    logic [4:0]  rk_round_out;
    logic        rd_done_out;
    logic        error_out;

    modport master (
        output key_start_in, key_valid_in, key_round_in, round_key_in, rd_start_in, decrypt_in,
        input  key_ready_out, rk_valid_out, rk_out, rk_round_out, rd_done_out, error_out
    );

    modport slave (
        input  key_start_in, key_valid_in, key_round_in, round_key_in, rd_start_in, decrypt_in,
        output key_ready_out, rk_valid_out, rk_out, rk_round_out, rd_done_out, error_out
    );
endinterface

// File: rtl/sm4_round_key_buffer.sv
// Stores one 32-entry SM4 round-key schedule written in order, then streams it
// forward (encrypt) or reversed (decrypt) once per block, with registered outputs.
module sm4_round_key_buffer (
    input  logic                        clk,
    input  logic                        rst,
    sm4_round_key_buffer_if.slave       kb
);
    typedef enum logic [1:0] {EMPTY, LOADING, READY, STREAMING} state_t;

    state_t      r_state, w_nxt_state;
    logic [4:0]  r_wr_idx, w_nxt_wr_idx;
    logic [4:0]  r_rd_cnt, w_nxt_rd_cnt;
    logic        r_decrypt, w_nxt_decrypt;
    logic        w_store, w_err, w_stream;
    logic [4:0]  w_rd_idx;
    logic [31:0] r_mem [32];

    logic        r_key_ready, r_rk_valid, r_rd_done, r_error;
    logic [31:0] r_rk;
    logic [4:0]  r_rk_round;

    always_comb begin
        w_nxt_state   = r_state;
        w_nxt_wr_idx  = r_wr_idx;
        w_nxt_rd_cnt  = r_rd_cnt;
        w_nxt_decrypt = r_decrypt;
        w_store       = 1'b0;
        w_err         = 1'b0;
        case (r_state)
            EMPTY: w_err = kb.key_valid_in | kb.rd_start_in;
            LOADING: begin
                w_err = kb.rd_start_in;
                if (kb.key_valid_in) begin
                    if (kb.key_round_in == r_wr_idx) begin
                        w_store      = 1'b1;
                        w_nxt_wr_idx = r_wr_idx + 5'd1;
                        if (r_wr_idx == 5'd31) w_nxt_state = READY;
                    end else begin
                        w_err       = 1'b1;
                        w_nxt_state = EMPTY;
                    end
                end
            end
            READY: begin
                w_err = kb.key_valid_in;
                if (kb.rd_start_in) begin
                    w_nxt_state   = STREAMING;
                    w_nxt_rd_cnt  = 5'd0;
                    w_nxt_decrypt = kb.decrypt_in;
                end
            end
            STREAMING: begin
                w_err = kb.key_valid_in;
                // r_rd_cnt is the round currently on rk_out; a start on the last
                // round chains straight into the next stream.
                if (r_rd_cnt == 5'd31) begin
                    if (kb.rd_start_in) begin
                        w_nxt_rd_cnt  = 5'd0;
                        w_nxt_decrypt = kb.decrypt_in;
                    end else begin
                        w_nxt_state = READY;
                    end
                end else begin
                    w_nxt_rd_cnt = r_rd_cnt + 5'd1;
                    if (kb.rd_start_in) w_err = 1'b1;
                end
            end
            default: w_nxt_state = EMPTY;
        endcase
        if (kb.key_start_in) begin
            w_nxt_state  = LOADING;
            w_nxt_wr_idx = 5'd0;
            w_store      = 1'b0;
            if (kb.rd_start_in) w_err = 1'b1;
        end
    end

    assign w_stream = (w_nxt_state == STREAMING);
    // 31 - n on a 5-bit index is its bitwise complement.
    assign w_rd_idx = w_nxt_decrypt ? ~w_nxt_rd_cnt : w_nxt_rd_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= EMPTY;
            r_wr_idx    <= 5'd0;
            r_rd_cnt    <= 5'd0;
            r_decrypt   <= 1'b0;
            r_key_ready <= 1'b0;
            r_rk_valid  <= 1'b0;
            r_rk        <= 32'd0;
            r_rk_round  <= 5'd0;
            r_rd_done   <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_state     <= w_nxt_state;
            r_wr_idx    <= w_nxt_wr_idx;
            r_rd_cnt    <= w_nxt_rd_cnt;
            r_decrypt   <= w_nxt_decrypt;
            r_key_ready <= (w_nxt_state == READY) || w_stream;
            r_rk_valid  <= w_stream;
            r_rk        <= w_stream ? r_mem[w_rd_idx] : 32'd0;
            r_rk_round  <= w_stream ? w_nxt_rd_cnt : 5'd0;
            r_rd_done   <= w_stream && (w_nxt_rd_cnt == 5'd31);
            r_error     <= w_err;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_store) r_mem[r_wr_idx] <= kb.round_key_in;
    end

    assign kb.key_ready_out = r_key_ready;
    assign kb.rk_valid_out  = r_rk_valid;
    assign kb.rk_out        = r_rk;
    assign kb.rk_round_out  = r_rk_round;
    assign kb.rd_done_out   = r_rd_done;
    assign kb.error_out     = r_error;
endmodule
